// File: rtl/histo_pkg.sv
// histo_pkg: default geometry, readout FSM state type and count saturation limit
// shared by histo_reader and its helpers.
package histo_pkg;

  localparam int unsigned HISTO_NUM_BINS = 256;
  localparam int unsigned HISTO_BIN_W    = 8;
  localparam int unsigned HISTO_CNT_W    = 20;

  localparam logic [HISTO_CNT_W-1:0] HISTO_CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    DONE
  } histo_state_e;

endpackage

// File: rtl/histo_reader_fval_edge_det.sv
// fval_edge_det: registers the frame-valid input twice and produces one-cycle
// rise/fall pulses from the two registered samples.
module fval_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic sample_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= d_i;
      prev_q   <= sample_q;
    end
  end

  assign rise_o = sample_q & ~prev_q;
  assign fall_o = prev_q & ~sample_q;

endmodule

// File: rtl/histo_reader.sv
// histo_reader: on the end of a frame, walks every histogram bin, streams
// index/count/cumulative count out, and flags frame-valid activity while busy.
// Optional: define HISTO_RD_CLEAR_EN to zero each bin as it is handed off.
module histo_reader
  import histo_pkg::*;
#(
  parameter int unsigned NUM_BINS = HISTO_NUM_BINS,
  parameter int unsigned BIN_W    = HISTO_BIN_W,
  parameter int unsigned CNT_W    = HISTO_CNT_W
) (
  input  logic             iPclk,
  input  logic             iRST_n,
  input  logic             iFval,
  output logic             oRd_en,
  output logic [BIN_W-1:0] oRd_addr,
  input  logic [CNT_W-1:0] iRd_data,
  output logic             oWr_en,
  output logic [BIN_W-1:0] oWr_addr,
  output logic [CNT_W-1:0] oWr_data,
  output logic             oBin_valid,
  input  logic             iBin_ready,
  output logic [BIN_W-1:0] oBin_idx,
  output logic [CNT_W-1:0] oBin_cnt,
  output logic [CNT_W-1:0] oBin_cum,
  output logic             oBusy,
  output logic             oDone,
  output logic             oOverrun
);

  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(NUM_BINS - 1);

  histo_state_e     state_q, state_d;
  logic [BIN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cum_q, cum_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W:0]   cum_sum;
  logic             fval_rise;
  logic             fval_fall;
  logic             busy;
  logic             handshake;

  fval_edge_det u_fval_edge (
    .clk_i  (iPclk),
    .rst_ni (iRST_n),
    .d_i    (iFval),
    .rise_o (fval_rise),
    .fall_o (fval_fall)
  );

  assign busy      = (state_q != IDLE);
  assign handshake = (state_q == PRESENT) && iBin_ready;
  assign cum_sum   = {1'b0, cum_q} + {1'b0, iRd_data};

  always_ff @(posedge iPclk or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fval_fall) state_d = READ;
      READ:    state_d = WAIT;
      WAIT:    state_d = PRESENT;
      PRESENT: if (iBin_ready) state_d = (idx_q == LAST_IDX) ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame edges are only acted on in IDLE; while busy they merely set the sticky flag.
  always_comb begin
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cum_d     = cum_q;
    overrun_d = overrun_q | (busy & (fval_rise | fval_fall));
    if ((state_q == IDLE) && fval_fall) begin
      idx_d = '0;
      cnt_d = '0;
      cum_d = '0;
    end
    if (state_q == WAIT) begin
      cnt_d = iRd_data;
      cum_d = cum_sum[CNT_W] ? '1 : cum_sum[CNT_W-1:0];
    end
    if (handshake && (idx_q != LAST_IDX)) begin
      idx_d = idx_q + BIN_W'(1);
    end
    if (state_q == DONE) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge iPclk or negedge iRST_n) begin
    if (!iRST_n) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      cum_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      cum_q     <= cum_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    oRd_en     = (state_q == READ);
    oRd_addr   = (state_q == READ) ? idx_q : '0;
    oBin_valid = (state_q == PRESENT);
    oBin_idx   = idx_q;
    oBin_cnt   = cnt_q;
    oBin_cum   = cum_q;
    oBusy      = busy;
    oDone      = (state_q == DONE);
    oOverrun   = overrun_q;
`ifdef HISTO_RD_CLEAR_EN
    oWr_en     = handshake;
    oWr_addr   = handshake ? idx_q : '0;
    oWr_data   = '0;
`else
    oWr_en     = 1'b0;
    oWr_addr   = '0;
    oWr_data   = '0;
`endif
  end

endmodule

// File: tb/tb_histo_reader.sv
// tb_histo_reader: RAM model plus scoreboard of expected bin records; a table of
// fill patterns drives full readouts, hand-written sequences cover corner cases.
module tb_histo_reader;
  import histo_pkg::*;

  localparam int unsigned NB = HISTO_NUM_BINS;
  localparam int unsigned BW = HISTO_BIN_W;
  localparam int unsigned CW = HISTO_CNT_W;
  localparam int unsigned LIM = 2000;

  typedef struct {
    logic [BW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cum;
  } sb_t;

  typedef struct {
    int unsigned   kind;
    logic [CW-1:0] cnt_last;
    logic [CW-1:0] cum_last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fval = 1'b0;
  logic          rd_en;
  logic [BW-1:0] rd_addr;
  logic [CW-1:0] rd_data = '0;
  logic          wr_en;
  logic [BW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          bin_valid;
  logic          bin_ready = 1'b1;
  logic [BW-1:0] bin_idx;
  logic [CW-1:0] bin_cnt;
  logic [CW-1:0] bin_cum;
  logic          busy;
  logic          done;
  logic          overrun;

  logic [CW-1:0] mem [NB];
  sb_t           sb_q [$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            last_hs_cyc = 0;
  int            hs_cnt = 0;
  int            wr_cnt = 0;
  logic [CW-1:0] last_cnt = '0;
  logic [CW-1:0] last_cum = '0;
  vec_t          tbl [5];

  histo_reader #(
    .NUM_BINS (NB),
    .BIN_W    (BW),
    .CNT_W    (CW)
  ) dut (
    .iPclk      (clk),
    .iRST_n     (rst_n),
    .iFval      (fval),
    .oRd_en     (rd_en),
    .oRd_addr   (rd_addr),
    .iRd_data   (rd_data),
    .oWr_en     (wr_en),
    .oWr_addr   (wr_addr),
    .oWr_data   (wr_data),
    .oBin_valid (bin_valid),
    .iBin_ready (bin_ready),
    .oBin_idx   (bin_idx),
    .oBin_cnt   (bin_cnt),
    .oBin_cum   (bin_cum),
    .oBusy      (busy),
    .oDone      (done),
    .oOverrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] = wr_data;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [CW-1:0] pat(input int unsigned kind, input int unsigned k);
    case (kind)
      0: return CW'(k);
      1: return HISTO_CNT_MAX;
      2: return CW'(1);
      4: return (k % 2 == 1) ? CW'(1000) : '0;
      default: return '0;
    endcase
  endfunction

  // Scoreboard side: every handshake pops one expected bin record.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) wr_cnt++;
      if (bin_valid && bin_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual_idx=%0d required=no_handshake", bin_idx);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("bin_idx", bin_idx, e.idx);
          check("bin_cnt", bin_cnt, e.cnt);
          check("bin_cum", bin_cum, e.cum);
          last_cnt    = bin_cnt;
          last_cum    = bin_cum;
          last_hs_cyc = cyc;
          hs_cnt++;
        end
      end
    end
  end

  task automatic start_frame(input int unsigned kind, input bit do_fill);
    logic [63:0] acc;
    acc = '0;
    if (do_fill) for (int unsigned k = 0; k < NB; k++) mem[k] = pat(kind, k);
    for (int unsigned k = 0; k < NB; k++) begin
      acc = acc + 64'(pat(kind, k));
      if (acc > 64'(HISTO_CNT_MAX)) acc = 64'(HISTO_CNT_MAX);
      sb_q.push_back('{idx: BW'(k), cnt: pat(kind, k), cum: CW'(acc)});
    end
    wr_cnt = 0;
    hs_cnt = 0;
    fval = 1'b1;
    step();
    step();
    fval = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (!done && n < LIM) begin
      step();
      n++;
    end
    check("done_seen", done, 1'b1);
    if (done) begin
      check("done_latency", cyc - last_hs_cyc, 1);
      check("handshakes", hs_cnt, NB);
`ifdef HISTO_RD_CLEAR_EN
      check("clear_writes", wr_cnt, NB);
`else
      check("clear_writes", wr_cnt, 0);
`endif
      step();
      check("done_pulse", {done, busy}, 2'b00);
    end
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    tbl[0] = '{kind: 0, cnt_last: 20'd255,     cum_last: 20'd32640};
    tbl[1] = '{kind: 1, cnt_last: 20'hFFFFF,   cum_last: 20'hFFFFF};
    tbl[2] = '{kind: 2, cnt_last: 20'd1,       cum_last: 20'd256};
    tbl[3] = '{kind: 3, cnt_last: 20'd0,       cum_last: 20'd0};
    tbl[4] = '{kind: 4, cnt_last: 20'd1000,    cum_last: 20'd128000};
    for (int unsigned k = 0; k < NB; k++) mem[k] = '0;

    step();
    step();
    check("reset_outputs", {rd_en, rd_addr, wr_en, wr_addr, wr_data, bin_valid, bin_idx,
                            bin_cnt, bin_cum, busy, done, overrun}, '0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_after_reset", {busy, bin_valid, rd_en}, 3'b000);

    // First-bin latency: falling edge sampled at N, read strobe at N+1, valid at N+3.
    start_frame(0, 1);
    step();
    check("lat_n_rd_en", {rd_en, busy}, 2'b00);
    step();
    check("lat_n1_rd_en", {rd_en, busy}, 2'b11);
    check("lat_n1_addr", rd_addr, 0);
    step();
    check("lat_n2_idle", {rd_en, bin_valid}, 2'b00);
    step();
    check("lat_n3_valid", bin_valid, 1'b1);
    check("lat_n3_idx", bin_idx, 0);
    wait_done();

    for (int i = 0; i < 5; i++) begin
      start_frame(tbl[i].kind, 1);
      wait_done();
      check($sformatf("tbl%0d_last_cnt", i), last_cnt, tbl[i].cnt_last);
      check($sformatf("tbl%0d_last_cum", i), last_cum, tbl[i].cum_last);
    end

    // Backpressure at bin 5.
    start_frame(0, 1);
    for (n = 0; n < LIM && !(rd_en && rd_addr == 5); n++) step();
    check("bp_reach_read5", rd_en && rd_addr == 5, 1'b1);
    bin_ready = 1'b0;
    for (n = 0; n < LIM && !bin_valid; n++) step();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i), {bin_valid, rd_en, bin_idx, bin_cnt, bin_cum},
            {1'b1, 1'b0, BW'(5), CW'(5), CW'(15)});
      step();
    end
    bin_ready = 1'b1;
    step();
    check("bp_resume", {rd_en, rd_addr}, {1'b1, BW'(6)});
    wait_done();

    // Frame-valid activity mid-readout.
    start_frame(0, 1);
    for (n = 0; n < LIM && !(bin_valid && bin_idx == 100); n++) step();
    check("ov_reach100", bin_valid && bin_idx == 100, 1'b1);
    check("ov_before", overrun, 1'b0);
    fval = 1'b1;
    step();
    fval = 1'b0;
    step();
    step();
    step();
    check("ov_after", {overrun, busy}, 2'b11);
    wait_done();
    check("ov_sticky", overrun, 1'b1);

    // Reset mid-readout abandons the frame and clears the sticky flag.
    start_frame(0, 1);
    for (n = 0; n < LIM && !(bin_valid && bin_idx == 50); n++) step();
    check("rst_reach50", bin_valid && bin_idx == 50, 1'b1);
    check("rst_ov_before", overrun, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {rd_en, rd_addr, wr_en, wr_addr, wr_data, bin_valid, bin_idx,
                              bin_cnt, bin_cum, busy, done, overrun}, '0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    step();
    start_frame(0, 1);
    wait_done();
    check("rst_ov_cleared", overrun, 1'b0);

    // Second readout without refilling RAM.
    start_frame(0, 1);
    wait_done();
`ifdef HISTO_RD_CLEAR_EN
    start_frame(3, 0);
    wait_done();
    check("second_last_cum", last_cum, 20'd0);
`else
    start_frame(0, 0);
    wait_done();
    check("second_last_cum", last_cum, 20'd32640);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/histo_reader.md
HISTO_READER -- requirements
Module: histo_reader

Interface
REQ-001 SHALL have parameter NUM_BINS, default 256, number of histogram bins.
REQ-002 SHALL have parameter BIN_W, default 8, bin address width (clog2 of NUM_BINS).
REQ-003 SHALL have parameter CNT_W, default 20, width of bin count and cumulative count.
REQ-004 SHALL use one clock and an asynchronous active-low reset; ports: iPclk  in  1  pixel clock.
REQ-005 iRST_n  in  1  asynchronous active-low reset.
REQ-006 iFval  in  1  frame valid from the CCD capture path.
REQ-007 oRd_en  out  1  histogram RAM read strobe.
REQ-008 oRd_addr  out  BIN_W  histogram RAM read address.
REQ-009 iRd_data  in  CNT_W  RAM read data, valid exactly 1 cycle after oRd_en.
REQ-010 oWr_en, oWr_addr[BIN_W], oWr_data[CNT_W]  out  bin clear write port.
REQ-011 oBin_valid  out  1, iBin_ready  in  1  output stream handshake.
REQ-012 oBin_idx  out  BIN_W, oBin_cnt  out  CNT_W, oBin_cum  out  CNT_W  bin index, count, running cumulative count.
REQ-013 oBusy  out  1, oDone  out  1 (one-cycle pulse), oOverrun  out  1 (sticky).

Function
REQ-014 SHALL register iFval and detect the falling edge: previous sample 1 and current sample 0.
REQ-015 SHALL use FSM states IDLE, READ, WAIT, PRESENT, DONE.
REQ-016 IDLE->READ on a falling edge; idx=0; cum=0.
REQ-017 READ: oRd_en=1 and oRd_addr=idx for exactly one cycle; next state is WAIT.
REQ-018 WAIT: capture iRd_data into oBin_cnt; cum<=cum+iRd_data, saturating at 2^CNT_W-1; next state is PRESENT.
REQ-019 PRESENT: oBin_valid=1; oBin_idx, oBin_cnt and oBin_cum SHALL stay stable until iBin_ready=1 in the same cycle.
REQ-020 On a PRESENT handshake: idx<NUM_BINS-1 -> idx+1 and go to READ; idx=NUM_BINS-1 -> go to DONE.
REQ-021 DONE: oDone=1 for one cycle, then IDLE.
REQ-022 oBusy SHALL be 1 in every state except IDLE.
REQ-023 Latency: oBin_valid SHALL rise 3 cycles after the cycle the falling edge is sampled; with iBin_ready held at 1, each bin takes 3 cycles.
REQ-024 iBin_ready may stay low indefinitely; the FSM SHALL stall in PRESENT with outputs held.
REQ-025 A falling edge while oBusy=1 SHALL set oOverrun and SHALL NOT restart the readout.
REQ-026 A rising iFval while oBusy=1 SHALL set oOverrun; the readout continues.
REQ-027 oOverrun SHALL clear only on reset.
REQ-028 oBin_valid SHALL never be 1 outside PRESENT.

Reset
REQ-029 Assertion of iRST_n=0 SHALL immediately force state IDLE and idx=0, and set every output to 0, including oRd_en, oWr_en, oBin_valid, oBusy, oDone, oOverrun, all addresses, data, counts and the sampled iFval.
REQ-030 A reset mid-readout SHALL abandon the frame; after reset the next falling edge starts from bin 0.

Configuration
REQ-031 Macro HISTO_RD_CLEAR_EN defined: on each PRESENT handshake, drive oWr_en=1, oWr_addr=idx, oWr_data=0 in that same cycle, so every bin reads zero after DONE.
REQ-032 Macro HISTO_RD_CLEAR_EN undefined: oWr_en, oWr_addr and oWr_data SHALL be constant 0 and RAM contents SHALL be untouched.

Structure
REQ-033 Package histo_pkg SHALL hold NUM_BINS, BIN_W, CNT_W defaults, the FSM state type, and the saturation maximum constant.
REQ-034 A sub-module fval_edge_det (registered sample, rise and fall pulses) SHALL be instantiated once.

Verification
REQ-035 RAM model with bin k = k, iBin_ready=1, iFval 1->0 -> 256 handshakes; oBin_cum at idx 255 = 32640; oDone 1 cycle after the last handshake.
REQ-036 First-bin latency: falling edge sampled at cycle N -> oRd_en at N+1 with addr 0, oBin_valid at N+3.
REQ-037 Backpressure: iBin_ready=0 for 10 cycles at idx 5 -> outputs frozen for 10 cycles, no oRd_en; resumes at idx 6 when ready.
REQ-038 All bins 0xFFFFF, CNT_W=20 -> oBin_cum saturates at 0xFFFFF from idx 1 onward.
REQ-039 iFval toggles 1->0 at idx 100 -> oOverrun=1 and the readout completes all 256 bins; iRST_n pulse at idx 50 -> all outputs 0, oOverrun cleared.
REQ-040 With HISTO_RD_CLEAR_EN, a second readout returns all counts 0; without it, the second readout equals the first.
